dfdd_frame_sequencer: RTL and testbench

Frame-level controller in front of the dual-scale DFDD pipeline (preprocessor → zero/first scale → adder → box filters → divider).
- Accepts uint8 ρ+/ρ− pixel pairs over a valid/ready handshake and stamps each with raster col/row.
- Shadows the per-frame configuration bundle (weights, zone a/b, r², centre) so it only changes between frames.
- Counts pipeline outputs to detect frame completion or a stall, and inserts a blanking gap before the next frame.

---
 rtl/dfdd_seq_pkg.sv | 19 +
 rtl/dfdd_raster_counter.sv | 40 ++++
 rtl/dfdd_frame_sequencer.sv | 148 ++++++++++++++
 tb/tb_dfdd_frame_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfdd_seq_pkg.sv
// rtl/dfdd_seq_pkg.sv - shared constants, state encoding and helpers for the DFDD frame sequencer
package dfdd_seq_pkg;

  localparam int COORD_W   = 16;
  localparam int OUT_CNT_W = 32;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 3'd0;
  localparam seq_state_t ST_ARM    = 3'd1;
  localparam seq_state_t ST_STREAM = 3'd2;
  localparam seq_state_t ST_DRAIN  = 3'd3;
  localparam seq_state_t ST_GAP    = 3'd4;

  function automatic logic [OUT_CNT_W-1:0] frame_pixels(input int w, input int h);
    return OUT_CNT_W'(w * h);
  endfunction

endpackage

// File: rtl/dfdd_raster_counter.sv
// rtl/dfdd_raster_counter.sv - raster col/row counter with enable, clear and last-pixel flag
module dfdd_raster_counter
  import dfdd_seq_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               last
);

  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(HEIGHT - 1);

  assign last = (col == COL_LAST) && (row == ROW_LAST);

  // Advance one pixel per enable, wrapping col into row and row back to the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dfdd_frame_sequencer.sv
// rtl/dfdd_frame_sequencer.sv - frame-level controller feeding the dual-scale DFDD pipeline
module dfdd_frame_sequencer
  import dfdd_seq_pkg::*;
#(
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int CFG_WIDTH     = 512,
  parameter int GAP_CYCLES    = 64,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 continuous_i,
  input  logic [CFG_WIDTH-1:0] cfg_i,
  input  logic                 cfg_load_i,
  output logic [CFG_WIDTH-1:0] cfg_active_o,
  input  logic [7:0]           pix_plus_i,
  input  logic [7:0]           pix_minus_i,
  input  logic                 pix_valid_i,
  output logic                 pix_ready_o,
  output logic [7:0]           dp_plus_o,
  output logic [7:0]           dp_minus_o,
  output logic [COORD_W-1:0]   dp_col_o,
  output logic [COORD_W-1:0]   dp_row_o,
  output logic                 dp_valid_o,
  input  logic                 dp_valid_i,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 timeout_o,
  output logic [15:0]          frame_cnt_o
);

  localparam logic [OUT_CNT_W-1:0] TOTAL_PIX   = frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam logic [OUT_CNT_W-1:0] TIMEOUT_VAL = OUT_CNT_W'(DRAIN_TIMEOUT);
  localparam logic [OUT_CNT_W-1:0] GAP_LAST    = OUT_CNT_W'(GAP_CYCLES - 1);

  seq_state_t           state;
  logic [CFG_WIDTH-1:0] cfg_staged;
  logic [COORD_W-1:0]   col;
  logic [COORD_W-1:0]   row;
  logic                 last_pix;
  logic [OUT_CNT_W-1:0] out_cnt;
  logic [OUT_CNT_W-1:0] idle_cnt;
  logic [OUT_CNT_W-1:0] idle_next;
  logic [OUT_CNT_W-1:0] gap_cnt;
  logic                 accept;
  logic                 drain_ok;
  logic                 drain_to;
  logic                 gap_last;

  assign pix_ready_o  = (state == ST_STREAM);
  assign accept       = pix_valid_i & pix_ready_o;
  assign busy_o       = (state != ST_IDLE);
  assign idle_next    = dp_valid_i ? '0 : idle_cnt + 1'b1;
  // Completion takes priority over a timeout that matures in the same cycle
  assign drain_ok     = (state == ST_DRAIN) && (out_cnt == TOTAL_PIX);
  assign drain_to     = (state == ST_DRAIN) && !drain_ok && (idle_next == TIMEOUT_VAL);
  assign gap_last     = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  assign timeout_o    = drain_to;
  assign frame_done_o = gap_last;

  dfdd_raster_counter #(
    .WIDTH  (IMAGE_WIDTH),
    .HEIGHT (IMAGE_HEIGHT)
  ) u_raster (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clr   (state == ST_ARM),
    .en    (accept),
    .col   (col),
    .row   (row),
    .last  (last_pix)
  );

  // Staged config accepts writes at any time; only ARM copies it to the active set
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cfg_staged <= '0;
    end else if (cfg_load_i) begin
      cfg_staged <= cfg_i;
    end
  end

  // Register each accepted pixel with its raster position; data holds between accepts
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dp_valid_o <= 1'b0;
      dp_plus_o  <= '0;
      dp_minus_o <= '0;
      dp_col_o   <= '0;
      dp_row_o   <= '0;
    end else begin
      dp_valid_o <= accept;
      if (accept) begin
        dp_plus_o  <= pix_plus_i;
        dp_minus_o <= pix_minus_i;
        dp_col_o   <= col;
        dp_row_o   <= row;
      end
    end
  end

  // Frame FSM with output counting, drain watchdog and blanking gap
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      cfg_active_o <= '0;
      out_cnt      <= '0;
      idle_cnt     <= '0;
      gap_cnt      <= '0;
      frame_cnt_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) state <= ST_ARM;
        end
        ST_ARM: begin
          cfg_active_o <= cfg_staged;
          out_cnt      <= '0;
          idle_cnt     <= '0;
          state        <= ST_STREAM;
        end
        ST_STREAM: begin
          if (dp_valid_i) out_cnt <= out_cnt + 1'b1;
          if (accept && last_pix) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (dp_valid_i) out_cnt <= out_cnt + 1'b1;
          idle_cnt <= idle_next;
          if (drain_ok || drain_to) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_last) begin
            frame_cnt_o <= frame_cnt_o + 1'b1;
            state       <= continuous_i ? ST_ARM : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfdd_frame_sequencer.sv
// tb/tb_dfdd_frame_sequencer.sv - directed self-checking bench for dfdd_frame_sequencer
module tb_dfdd_frame_sequencer;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic [7:0]  cfg_i = '0;
  logic        cfg_load_i = 1'b0;
  logic [7:0]  cfg_active_o;
  logic [7:0]  pix_plus_i = '0;
  logic [7:0]  pix_minus_i = '0;
  logic        pix_valid_i = 1'b0;
  logic        pix_ready_o;
  logic [7:0]  dp_plus_o;
  logic [7:0]  dp_minus_o;
  logic [15:0] dp_col_o;
  logic [15:0] dp_row_o;
  logic        dp_valid_o;
  logic        dp_valid_i = 1'b0;
  logic        busy_o;
  logic        frame_done_o;
  logic        timeout_o;
  logic [15:0] frame_cnt_o;

  int checks = 0;
  int failures = 0;

  dfdd_frame_sequencer #(
    .IMAGE_WIDTH   (W),
    .IMAGE_HEIGHT  (H),
    .CFG_WIDTH     (8),
    .GAP_CYCLES    (2),
    .DRAIN_TIMEOUT (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .continuous_i (continuous_i),
    .cfg_i        (cfg_i),
    .cfg_load_i   (cfg_load_i),
    .cfg_active_o (cfg_active_o),
    .pix_plus_i   (pix_plus_i),
    .pix_minus_i  (pix_minus_i),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .dp_plus_o    (dp_plus_o),
    .dp_minus_o   (dp_minus_o),
    .dp_col_o     (dp_col_o),
    .dp_row_o     (dp_row_o),
    .dp_valid_o   (dp_valid_o),
    .dp_valid_i   (dp_valid_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .timeout_o    (timeout_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  // cycle index, advanced on every rising edge
  int cyc = 0;
  always @(posedge clk) cyc++;

  // pipeline stand-in: echoes dp_valid_o back as dp_valid_i, optionally capped in count
  logic [9:0] pipe = '0;
  int emit_cnt = 0;
  int emit_limit = 1 << 30;
  always @(posedge clk) begin
    #1;
    pipe = {pipe[8:0], dp_valid_o};
    if (pipe[9] && emit_cnt < emit_limit) begin
      dp_valid_i = 1'b1;
      emit_cnt++;
    end else begin
      dp_valid_i = 1'b0;
    end
  end

  // monitor, sampled mid-cycle on the falling edge
  logic [47:0] out_q[$];
  int   done_n = 0;
  int   to_n = 0;
  int   to_cyc = 0;
  int   dpvi_cyc = 0;
  int   idle_n = 0;
  int   lat_err = 0;
  logic acc_prev = 1'b0;
  always @(negedge clk) begin
    if (dp_valid_o) out_q.push_back({dp_row_o, dp_col_o, dp_plus_o, dp_minus_o});
    if (frame_done_o) done_n++;
    if (timeout_o) begin
      to_n++;
      to_cyc = cyc;
    end
    if (dp_valid_i) dpvi_cyc = cyc;
    if (!busy_o) idle_n++;
    if (rst_i && (dp_valid_o !== acc_prev)) lat_err++;
    acc_prev = rst_i && pix_valid_i && pix_ready_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] exp_before, input logic [7:0] exp_after,
                             input bit arm_load, input logic [7:0] arm_val);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("arm_busy", 64'(busy_o), 64'(1));
    chk("arm_ready", 64'(pix_ready_o), 64'(0));
    chk("cfg_in_arm", 64'(cfg_active_o), 64'(exp_before));
    if (arm_load) begin
      cfg_i = arm_val;
      cfg_load_i = 1'b1;
    end
    tick();
    cfg_load_i = 1'b0;
    chk("cfg_after_arm", 64'(cfg_active_o), 64'(exp_after));
    chk("stream_ready", 64'(pix_ready_o), 64'(1));
  endtask

  task automatic send_frame(input int n_pix, input int density, input logic [7:0] base,
                            input bit pulse_start);
    int idx;
    int guard;
    int miss;
    logic v;
    logic rdy;
    logic [7:0] d;
    idx = 0;
    guard = 0;
    miss = 0;
    while (idx < n_pix && guard < 400) begin
      v = (miss >= 3) || (int'($urandom_range(0, 99)) < density);
      d = base + 8'(idx);
      pix_valid_i = v;
      pix_plus_i = d;
      pix_minus_i = ~d;
      rdy = pix_ready_o;
      start_i = pulse_start && rdy;
      tick();
      if (rdy) miss = v ? 0 : miss + 1;
      if (v && rdy) idx++;
      guard++;
    end
    pix_valid_i = 1'b0;
    start_i = 1'b0;
    chk("pixels_sent", 64'(idx), 64'(n_pix));
  endtask

  task automatic wait_done(input bit clear_cont);
    int n;
    n = 0;
    while (!frame_done_o && n < 200) begin
      tick();
      n++;
    end
    chk("frame_done_seen", 64'(frame_done_o), 64'(1));
    if (clear_cont) continuous_i = 1'b0;
    tick();
  endtask

  task automatic check_frame(input int out_base, input logic [7:0] base);
    logic [7:0] d;
    logic [47:0] e;
    chk("out_count", 64'(out_q.size() - out_base), 64'(NPIX));
    for (int i = 0; i < NPIX; i++) begin
      if (out_base + i < out_q.size()) begin
        d = base + 8'(i);
        e = {16'(i / W), 16'(i % W), d, ~d};
        chk("raster_pixel", 64'(out_q[out_base + i]), 64'(e));
      end
    end
    chk("latency_1cyc", 64'(lat_err), 64'(0));
  endtask

  int ob;
  int d0;
  int t0;
  int i0;

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_cfg_active", 64'(cfg_active_o), 64'(0));
    chk("rst_frame_cnt", 64'(frame_cnt_o), 64'(0));
    chk("rst_pix_ready", 64'(pix_ready_o), 64'(0));
    chk("rst_dp_valid", 64'(dp_valid_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(frame_done_o), 64'(0));
    chk("rst_timeout", 64'(timeout_o), 64'(0));
    chk("rst_dp_col", 64'(dp_col_o), 64'(0));
    chk("rst_dp_row", 64'(dp_row_o), 64'(0));
    rst_i = 1'b1;
    tick();

    // single frame, always-valid input, config 0xA5
    cfg_i = 8'hA5;
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    chk("idle_ready", 64'(pix_ready_o), 64'(0));
    ob = out_q.size();
    d0 = done_n;
    t0 = to_n;
    start_frame(8'h00, 8'hA5, 1'b0, 8'h00);
    send_frame(NPIX, 100, 8'h10, 1'b0);
    wait_done(1'b0);
    check_frame(ob, 8'h10);
    chk("t1_done_pulses", 64'(done_n - d0), 64'(1));
    chk("t1_no_timeout", 64'(to_n - t0), 64'(0));
    chk("t1_frame_cnt", 64'(frame_cnt_o), 64'(1));
    chk("t1_idle", 64'(busy_o), 64'(0));

    // backpressure at ~50% density plus a config load during STREAM
    ob = out_q.size();
    start_frame(8'hA5, 8'hA5, 1'b0, 8'h00);
    cfg_i = 8'h11;
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    send_frame(NPIX, 50, 8'h40, 1'b0);
    chk("t2_cfg_held", 64'(cfg_active_o), 64'(8'hA5));
    wait_done(1'b0);
    check_frame(ob, 8'h40);
    chk("t2_cfg_held_gap", 64'(cfg_active_o), 64'(8'hA5));
    chk("t2_frame_cnt", 64'(frame_cnt_o), 64'(2));

    // ARM-cycle load: active takes the earlier staged 0x11, 0x22 waits a frame
    ob = out_q.size();
    start_frame(8'hA5, 8'h11, 1'b1, 8'h22);
    send_frame(NPIX, 100, 8'hC0, 1'b0);
    wait_done(1'b0);
    check_frame(ob, 8'hC0);
    chk("t3_frame_cnt", 64'(frame_cnt_o), 64'(3));

    // drain stall: only 11 outputs come back, timeout after 8 idle cycles
    emit_limit = emit_cnt + 11;
    d0 = done_n;
    t0 = to_n;
    ob = out_q.size();
    start_frame(8'h11, 8'h22, 1'b0, 8'h00);
    send_frame(NPIX, 100, 8'h80, 1'b0);
    wait_done(1'b0);
    emit_limit = 1 << 30;
    chk("t4_dp_valid_count", 64'(out_q.size() - ob), 64'(NPIX));
    chk("t4_timeout_pulses", 64'(to_n - t0), 64'(1));
    chk("t4_timeout_delay", 64'(to_cyc - dpvi_cyc), 64'(8));
    chk("t4_done_pulses", 64'(done_n - d0), 64'(1));
    chk("t4_idle", 64'(busy_o), 64'(0));
    chk("t4_frame_cnt", 64'(frame_cnt_o), 64'(4));

    // continuous mode: three back-to-back frames, stray start pulses during STREAM
    continuous_i = 1'b1;
    d0 = done_n;
    ob = out_q.size();
    start_frame(8'h22, 8'h22, 1'b0, 8'h00);
    i0 = idle_n;
    send_frame(NPIX, 100, 8'h01, 1'b1);
    wait_done(1'b0);
    check_frame(ob, 8'h01);
    ob = out_q.size();
    send_frame(NPIX, 100, 8'h21, 1'b1);
    wait_done(1'b0);
    check_frame(ob, 8'h21);
    ob = out_q.size();
    send_frame(NPIX, 100, 8'h61, 1'b1);
    wait_done(1'b1);
    check_frame(ob, 8'h61);
    chk("t5_no_idle_between", 64'(idle_n - i0), 64'(0));
    chk("t5_done_pulses", 64'(done_n - d0), 64'(3));
    chk("t5_frame_cnt", 64'(frame_cnt_o), 64'(7));
    chk("t5_back_to_idle", 64'(busy_o), 64'(0));

    // asynchronous reset after the fifth accepted pixel
    d0 = done_n;
    t0 = to_n;
    start_frame(8'h22, 8'h22, 1'b0, 8'h00);
    send_frame(5, 100, 8'h50, 1'b0);
    chk("t6_pre_valid", 64'(dp_valid_o), 64'(1));
    chk("t6_pre_pos", 64'({dp_row_o, dp_col_o}), 64'({16'd1, 16'd0}));
    rst_i = 1'b0;
    #1;
    chk("t6_rst_dp_valid", 64'(dp_valid_o), 64'(0));
    chk("t6_rst_dp_data", 64'({dp_row_o, dp_col_o, dp_plus_o, dp_minus_o}), 64'(0));
    chk("t6_rst_cfg", 64'(cfg_active_o), 64'(0));
    chk("t6_rst_busy", 64'(busy_o), 64'(0));
    chk("t6_rst_ready", 64'(pix_ready_o), 64'(0));
    chk("t6_rst_frame_cnt", 64'(frame_cnt_o), 64'(0));
    repeat (3) tick();
    rst_i = 1'b1;
    repeat (15) tick();
    chk("t6_no_done", 64'(done_n - d0), 64'(0));
    chk("t6_no_timeout", 64'(to_n - t0), 64'(0));
    ob = out_q.size();
    start_frame(8'h00, 8'h00, 1'b0, 8'h00);
    send_frame(NPIX, 100, 8'h70, 1'b0);
    wait_done(1'b0);
    check_frame(ob, 8'h70);
    chk("t6_frame_cnt", 64'(frame_cnt_o), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
